// File: rtl/des_pkg.sv
// DES key schedule shared definitions: FSM states, shift
// schedule, and the PC-1 / PC-2 bit-selection wiring.
package des_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Left-rotation amount per round, index = round - 1
    localparam logic [1:0] SHIFTS [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // PC-1: 64-bit key (MSB = DES bit 1) to {C,D}, C in the MSBs.
    // Parity bits (LSB of every byte) never appear here.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        return {
            k[7],  k[15], k[23], k[31], k[39], k[47], k[55],
            k[63], k[6],  k[14], k[22], k[30], k[38], k[46],
            k[54], k[62], k[5],  k[13], k[21], k[29], k[37],
            k[45], k[53], k[61], k[4],  k[12], k[20], k[28],
            k[1],  k[9],  k[17], k[25], k[33], k[41], k[49],
            k[57], k[2],  k[10], k[18], k[26], k[34], k[42],
            k[50], k[58], k[3],  k[11], k[19], k[27], k[35],
            k[43], k[51], k[59], k[36], k[44], k[52], k[60]
        };
    endfunction

    // PC-2: 56-bit {C,D} (MSB = bit 1) to 48-bit subkey
    function automatic logic [47:0] pc2(input logic [55:0] cd);
        return {
            cd[42], cd[39], cd[45], cd[32], cd[55], cd[51],
            cd[53], cd[28], cd[41], cd[50], cd[35], cd[46],
            cd[33], cd[37], cd[44], cd[52], cd[30], cd[48],
            cd[40], cd[49], cd[29], cd[36], cd[43], cd[54],
            cd[15], cd[4],  cd[25], cd[19], cd[9],  cd[1],
            cd[26], cd[16], cd[5],  cd[11], cd[23], cd[8],
            cd[12], cd[7],  cd[17], cd[0],  cd[22], cd[3],
            cd[10], cd[14], cd[6],  cd[20], cd[27], cd[24]
        };
    endfunction

    function automatic logic [27:0] rotl28(
        input logic [27:0] x,
        input logic        two
    );
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(
        input logic [27:0] x,
        input logic        two
    );
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

endpackage

// File: rtl/des_pc2.sv
// Permuted choice 2: combinational 56-bit {C,D} to
// 48-bit round subkey.
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] i_cd,
    output logic [47:0] o_subkey
);

    assign o_subkey = pc2(i_cd);

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: streams 16 round subkeys over
// a valid/ready handshake, forward or reverse order.
module des_key_schedule
    import des_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [63:0] i_key,
    input  logic        i_decrypt,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_subkey_valid,
    output logic [47:0] o_subkey,
    output logic [3:0]  o_round,
    input  logic        i_ready,
    output logic        o_done
);

    state_t      r_state;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic [3:0]  r_step;
    logic        r_mode;
    logic        r_done;

    logic [55:0] w_pc1;
    logic [3:0]  w_sidx;
    logic        w_two;
    logic        w_fire;
    logic [27:0] w_c_nx;
    logic [27:0] w_d_nx;

    assign w_pc1  = pc1(i_key);
    assign w_fire = (r_state == ST_RUN) && i_ready;

    // Encrypt wants s(next round); decrypt undoes s(current
    // round), which is 16 - step in DES numbering.
    assign w_sidx = r_mode ? (4'd15 - r_step)
                           : (r_step + 4'd1);
    assign w_two  = (SHIFTS[w_sidx] == 2'd2);

    // Next C/D for the following subkey in either direction
    always_comb begin
        w_c_nx = r_c;
        w_d_nx = r_d;
        if (r_mode) begin
            w_c_nx = rotr28(r_c, w_two);
            w_d_nx = rotr28(r_d, w_two);
        end else begin
            w_c_nx = rotl28(r_c, w_two);
            w_d_nx = rotl28(r_d, w_two);
        end
    end

    // Control FSM plus C/D, step and done-pulse registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_c     <= '0;
            r_d     <= '0;
            r_step  <= '0;
            r_mode  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        // Decrypt starts at C0D0 == C16D16
                        if (i_decrypt) begin
                            r_c <= w_pc1[55:28];
                            r_d <= w_pc1[27:0];
                        end else begin
                            r_c <= rotl28(w_pc1[55:28], 1'b0);
                            r_d <= rotl28(w_pc1[27:0], 1'b0);
                        end
                        r_mode  <= i_decrypt;
                        r_step  <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_fire) begin
                        if (r_step == 4'd15) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_step <= r_step + 4'd1;
                            r_c    <= w_c_nx;
                            r_d    <= w_d_nx;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    des_pc2 u_pc2 (
        .i_cd     ({r_c, r_d}),
        .o_subkey (o_subkey)
    );

    assign o_busy         = (r_state == ST_RUN);
    assign o_subkey_valid = (r_state == ST_RUN);
    assign o_done         = r_done;
    assign o_round        = r_mode ? (4'd15 - r_step) : r_step;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule against a
// table-driven DES key schedule model.
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [63:0] i_key;
    logic        i_decrypt;
    logic        i_start;
    logic        o_busy;
    logic        o_subkey_valid;
    logic [47:0] o_subkey;
    logic [3:0]  o_round;
    logic        i_ready;
    logic        o_done;

    int n_chk  = 0;
    int n_pass = 0;

    logic [47:0] got     [16];
    logic [47:0] enc_ref [16];

    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

    int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2,
                    1, 2, 2, 2, 2, 2, 2, 1};

    des_key_schedule dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_key          (i_key),
        .i_decrypt      (i_decrypt),
        .i_start        (i_start),
        .o_busy         (o_busy),
        .o_subkey_valid (o_subkey_valid),
        .o_subkey       (o_subkey),
        .o_round        (o_round),
        .i_ready        (i_ready),
        .o_done         (o_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    // Bit n (1 = MSB) of a width-bit value held in v
    function automatic logic bitn(input logic [63:0] v,
                                  input int width,
                                  input int n);
        logic [63:0] t;
        t = v >> (width - n);
        return t[0];
    endfunction

    function automatic logic [27:0] rl(input logic [27:0] x,
                                       input int n);
        logic [55:0] t;
        t = {x, x} << n;
        return t[55:28];
    endfunction

    // Ki = PC2(rotl(C0, total shift), rotl(D0, total shift))
    function automatic void model(input logic [63:0] key,
                                  output logic [47:0] ks [16]);
        logic [27:0] c0, d0, c, d;
        logic [55:0] cd;
        logic [47:0] k;
        int tot;
        c0 = '0;
        d0 = '0;
        for (int i = 0; i < 28; i++) begin
            c0 = {c0[26:0], bitn(key, 64, PC1[i])};
            d0 = {d0[26:0], bitn(key, 64, PC1[28 + i])};
        end
        tot = 0;
        for (int r = 0; r < 16; r++) begin
            tot += SH[r];
            c = rl(c0, tot % 28);
            d = rl(d0, tot % 28);
            cd = {c, d};
            k = '0;
            for (int j = 0; j < 48; j++)
                k = {k[46:0], bitn({8'h00, cd}, 56, PC2[j])};
            ks[r] = k;
        end
    endfunction

    task automatic start(input logic [63:0] key,
                         input logic dec);
        i_key     = key;
        i_decrypt = dec;
        i_start   = 1'b1;
        @(posedge clk);
        #1;
        i_start   = 1'b0;
        i_decrypt = ~dec;
        i_key     = ~key;
    endtask

    // Drive the consumer side for one schedule and score it.
    // start_at >= 0 pulses i_start with key2 at that cycle;
    // rst_after >= 0 resets after that many acceptances.
    task automatic stream(input logic [63:0] key,
                          input logic dec,
                          input bit rnd,
                          input int start_at,
                          input logic [63:0] key2,
                          input int rst_after);
        logic [47:0] exp_ks [16];
        logic [47:0] hk;
        logic [3:0]  hr;
        logic [3:0]  er;
        bit hold;
        int acc;
        int cyc;
        model(key, exp_ks);
        acc  = 0;
        cyc  = 0;
        hold = 0;
        hk   = '0;
        hr   = '0;
        while (acc < 16 && cyc < 400) begin
            if (rst_after >= 0 && acc == rst_after) begin
                i_ready = 1'b0;
                i_rst   = 1'b1;
                @(posedge clk);
                #1;
                i_rst = 1'b0;
                chk("rst_valid", 64'(o_subkey_valid), 0);
                chk("rst_busy", 64'(o_busy), 0);
                chk("rst_done", 64'(o_done), 0);
                return;
            end
            if (hold) begin
                chk("hold_key", 64'(o_subkey), 64'(hk));
                chk("hold_round", 64'(o_round), 64'(hr));
            end
            chk("valid", 64'(o_subkey_valid), 1);
            chk("busy", 64'(o_busy), 1);
            chk("early_done", 64'(o_done), 0);
            i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cyc == start_at) begin
                i_start = 1'b1;
                i_key   = key2;
            end
            if (i_ready) begin
                er = dec ? 4'(15 - acc) : 4'(acc);
                chk("subkey", 64'(o_subkey), 64'(exp_ks[er]));
                chk("round", 64'(o_round), 64'(er));
                got[acc] = o_subkey;
                acc++;
                hold = 0;
            end else begin
                hold = 1;
                hk   = o_subkey;
                hr   = o_round;
            end
            @(posedge clk);
            #1;
            i_start = 1'b0;
            cyc++;
        end
        chk("accepted", 64'(acc), 16);
        chk("done_pulse", 64'(o_done), 1);
        chk("busy_end", 64'(o_busy), 0);
        chk("valid_end", 64'(o_subkey_valid), 0);
    endtask

    initial begin
        i_rst     = 1'b1;
        i_key     = '0;
        i_decrypt = 1'b0;
        i_start   = 1'b0;
        i_ready   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_valid0", 64'(o_subkey_valid), 0);
        chk("rst_busy0", 64'(o_busy), 0);
        chk("rst_done0", 64'(o_done), 0);
        chk("rst_subkey0", 64'(o_subkey), 0);
        chk("rst_round0", 64'(o_round), 0);
        i_rst = 1'b0;
        @(posedge clk);
        #1;

        start(KEY, 1'b0);
        stream(KEY, 1'b0, 0, -1, '0, -1);
        chk("enc_k1", 64'(got[0]), 64'h1B02EFFC7072);
        chk("enc_k2", 64'(got[1]), 64'h79AED9DBC9E5);
        chk("enc_k16", 64'(got[15]), 64'hCB3D8B0E17F5);
        for (int i = 0; i < 16; i++) enc_ref[i] = got[i];
        @(posedge clk);
        #1;
        chk("done_once", 64'(o_done), 0);

        start(KEY, 1'b1);
        stream(KEY, 1'b1, 0, -1, '0, -1);
        chk("dec_first", 64'(got[0]), 64'hCB3D8B0E17F5);
        chk("dec_15th", 64'(got[14]), 64'h79AED9DBC9E5);
        chk("dec_last", 64'(got[15]), 64'h1B02EFFC7072);
        for (int i = 0; i < 16; i++)
            chk("dec_rev", 64'(got[i]), 64'(enc_ref[15 - i]));

        // back-to-back: start in the o_done cycle
        begin
            logic [63:0] k1;
            logic [63:0] k2;
            logic [63:0] k3;
            logic [63:0] k4;
            k1 = {$urandom, $urandom};
            k2 = {$urandom, $urandom};
            k3 = {$urandom, $urandom};
            k4 = {$urandom, $urandom};
            start(k1, 1'b0);
            stream(k1, 1'b0, 1, -1, '0, -1);
            start(k2, 1'b1);
            stream(k2, 1'b1, 1, -1, '0, -1);
            start(k3, 1'b0);
            stream(k3, 1'b0, 0, 3, k4, -1);
            @(posedge clk);
            #1;
            start(k4, 1'b1);
            stream(k4, 1'b1, 0, 5, k1, -1);
        end

        begin
            logic [63:0] k5;
            logic [63:0] k6;
            k5 = {$urandom, $urandom};
            k6 = {$urandom, $urandom};
            start(k5, 1'b0);
            stream(k5, 1'b0, 1, -1, '0, 7);
            @(posedge clk);
            #1;
            chk("rst_no_done", 64'(o_done), 0);
            start(k6, 1'b0);
            stream(k6, 1'b0, 1, -1, '0, -1);
        end

        start(KEY ^ 64'h0101010101010101, 1'b0);
        stream(KEY ^ 64'h0101010101010101, 1'b0, 0, -1, '0, -1);
        for (int i = 0; i < 16; i++)
            chk("parity", 64'(got[i]), 64'(enc_ref[i]));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
